// File: rtl/mips_pkg.sv
// Shared types and helpers for the multicycle MIPS datapath.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITER  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    function automatic logic [MD_WIDTH-1:0] neg2c(input logic [MD_WIDTH-1:0] x);
        return ~x + MD_WIDTH'(1);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module md_iter_core
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] work_hi,
    input  logic [WIDTH-1:0] work_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        addend  = work_lo[0] ? {1'b0, operand} : '0;
        sum     = {1'b0, work_hi} + addend;
        shifted = {work_hi, work_lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};

        if (mode_div) begin
            // Borrow out of the 33-bit subtract means restore.
            if (diff[WIDTH]) begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {work_lo[WIDTH-2:0], 1'b0};
            end else begin
                next_hi = diff[WIDTH-1:0];
                next_lo = {work_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], work_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide engine feeding the Hi/Lo registers.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITER  = MD_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_done,
    output logic             div_done,
    output logic             div_zero,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(ITER);

    md_state_t        state, state_d;
    logic [CNT_W-1:0] counter, counter_d;
    logic [WIDTH-1:0] work_hi, work_hi_d;
    logic [WIDTH-1:0] work_lo, work_lo_d;
    logic [WIDTH-1:0] operand, operand_d;
    logic             sign_q, sign_q_d;
    logic             sign_r, sign_r_d;
    logic             op_mult, op_mult_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             mult_done_d, div_done_d, div_zero_d, busy_d;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign abs_a = op_a[WIDTH-1] ? neg2c(op_a) : op_a;
    assign abs_b = op_b[WIDTH-1] ? neg2c(op_b) : op_b;

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .mode_div (state == DIV),
        .work_hi  (work_hi),
        .work_lo  (work_lo),
        .operand  (operand),
        .next_hi  (core_hi),
        .next_lo  (core_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        counter_d   = counter;
        work_hi_d   = work_hi;
        work_lo_d   = work_lo;
        operand_d   = operand;
        sign_q_d    = sign_q;
        sign_r_d    = sign_r;
        op_mult_d   = op_mult;
        hi_d        = hi;
        lo_d        = lo;
        mult_done_d = 1'b0;
        div_done_d  = 1'b0;
        div_zero_d  = 1'b0;

        case (state)
            IDLE: begin
                // Multiply has priority when both strobes arrive together.
                if (start_mult) begin
                    state_d   = MULT;
                    counter_d = '0;
                    work_hi_d = '0;
                    work_lo_d = abs_b;
                    operand_d = abs_a;
                    sign_q_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    sign_r_d  = 1'b0;
                    op_mult_d = 1'b1;
                end else if (start_div) begin
                    if (op_b == '0) begin
                        div_done_d = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d   = DIV;
                        counter_d = '0;
                        work_hi_d = '0;
                        work_lo_d = abs_a;
                        operand_d = abs_b;
                        sign_q_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        sign_r_d  = op_a[WIDTH-1];
                        op_mult_d = 1'b0;
                    end
                end
            end
            MULT, DIV: begin
                work_hi_d = core_hi;
                work_lo_d = core_lo;
                counter_d = counter + CNT_W'(1);
                if (counter == CNT_W'(ITER - 1)) begin
                    state_d   = FIX;
                    counter_d = '0;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (op_mult) begin
                    // 64-bit negate: low word negates, high word carries only when low is zero.
                    hi_d        = sign_q ? (~work_hi + WIDTH'(work_lo == '0)) : work_hi;
                    lo_d        = sign_q ? neg2c(work_lo) : work_lo;
                    mult_done_d = 1'b1;
                end else begin
                    hi_d       = sign_r ? neg2c(work_hi) : work_hi;
                    lo_d       = sign_q ? neg2c(work_lo) : work_lo;
                    div_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            operand   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            op_mult   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            mult_done <= 1'b0;
            div_done  <= 1'b0;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            counter   <= counter_d;
            work_hi   <= work_hi_d;
            work_lo   <= work_lo_d;
            operand   <= operand_d;
            sign_q    <= sign_q_d;
            sign_r    <= sign_r_d;
            op_mult   <= op_mult_d;
            hi        <= hi_d;
            lo        <= lo_d;
            mult_done <= mult_done_d;
            div_done  <= div_done_d;
            div_zero  <= div_zero_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations, monitor checks each done pulse.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_done;
    logic        div_done;
    logic        div_zero;
    logic        busy;

    typedef struct {
        logic        is_div;
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .mult_done  (mult_done),
        .div_done   (div_done),
        .div_zero   (div_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!reset && (mult_done || div_done)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got mult_done=%b div_done=%b expected no pulse",
                         mult_done, div_done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_mult_done"}, 64'(mult_done), 64'(!e.is_div));
                check({e.name, "_div_done"},  64'(div_done),  64'(e.is_div));
                check({e.name, "_div_zero"},  64'(div_zero),  64'(e.zero));
                check({e.name, "_hi"},        64'(hi),        64'(e.hi));
                check({e.name, "_lo"},        64'(lo),        64'(e.lo));
            end
        end else if (!reset && div_zero) begin
            checks++;
            errors++;
            $display("FAIL stray_div_zero: got div_zero=1 expected 0 without div_done");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one strobe, then count cycles until the done pulse is visible.
    task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit exp_zero, input int exp_cyc, input string name);
        exp_t e;
        int   cyc;
        int   done_at;
        e.is_div = is_div;
        e.zero   = exp_zero;
        e.hi     = exp_hi;
        e.lo     = exp_lo;
        e.name   = name;
        sb.push_back(e);
        op_a       = a;
        op_b       = b;
        start_mult = !is_div;
        start_div  = is_div;
        cyc        = 0;
        done_at    = 0;
        while (done_at == 0 && cyc < 100) begin
            step();
            cyc++;
            start_mult = 1'b0;
            start_div  = 1'b0;
            if (cyc == 1 && !exp_zero) check({name, "_busy_start"}, 64'(busy), 64'(1));
            if (mult_done || div_done) done_at = cyc;
        end
        check({name, "_latency"}, 64'(done_at), 64'(exp_cyc));
        check({name, "_busy_done"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int cyc;
        int done_at;
        exp_t e;

        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) step();
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_flags", 64'({mult_done, div_done, div_zero, busy}), 64'(0));
        reset = 1'b0;
        step();

        // 7 * -3 = -21
        do_op(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, "mul_7_m3");
        step();
        check("mul_7_m3_after", 64'({mult_done, busy}), 64'(0));

        // Most-negative squared, then a back-to-back start in the done cycle.
        do_op(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, "mul_min_min");
        do_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34, "mul_3_5");

        // -7 / 2: quotient -3, remainder -1
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, "div_m7_2");
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, "div_min_m1");

        // 0x451 / 0x20 = 0x22 rem 0x11, then divide by zero leaves that in place.
        do_op(1'b1, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34, "div_prime");
        do_op(1'b1, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1, "div_zero");
        step();
        check("div_zero_after", 64'({div_done, div_zero, busy}), 64'(0));

        // Strobe during an operation must be ignored: 1000 * -2 = -2000.
        e.is_div = 1'b0;
        e.zero   = 1'b0;
        e.hi     = 32'hFFFFFFFF;
        e.lo     = 32'hFFFFF830;
        e.name   = "mul_ignore";
        sb.push_back(e);
        op_a       = 32'd1000;
        op_b       = 32'hFFFFFFFE;
        start_mult = 1'b1;
        cyc        = 0;
        done_at    = 0;
        while (done_at == 0 && cyc < 100) begin
            step();
            cyc++;
            start_mult = 1'b0;
            if (cyc == 9) begin
                start_div = 1'b1;
                op_a      = 32'd77;
                op_b      = 32'd4;
            end else begin
                start_div = 1'b0;
            end
            if (mult_done || div_done) done_at = cyc;
        end
        check("mul_ignore_latency", 64'(done_at), 64'(34));
        repeat (40) step();
        check("mul_ignore_idle", 64'(busy), 64'(0));

        // Reset mid-divide aborts with no done pulse.
        op_a      = 32'd100;
        op_b      = 32'd7;
        start_div = 1'b1;
        step();
        start_div = 1'b0;
        repeat (14) step();
        check("abort_busy_before", 64'(busy), 64'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        repeat (40) step();
        check("abort_quiet", 64'({busy, mult_done, div_done}), 64'(0));

        do_op(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, "mul_6_7");

        repeat (3) step();
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus expected finish");
        $fatal(1);
    end

endmodule
